uart_byte_transmitter: RTL and testbench

//  Serialises one byte per TxD_start strobe onto the async TxD line: 8N1 frame, LSB first.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_byte_transmitter.sv | 180 ++++++++++++++++++
 tb/tb_uart_byte_transmitter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: FSM state encoding and baud divisor helper.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Rounded clocks-per-bit; evaluated at elaboration only.
  function automatic int baud_div(input longint clk_freq, input longint baud);
    return int'((clk_freq + baud / 2) / baud);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 0..DIV-1 bit-period counter with a one-cycle tick at DIV-1.
// Also intended for the receiver, instantiated with a 16x oversampling divisor.
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic master_clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int             W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]   TC = W'(DIV - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tick = (count_q == TC) && !clear;

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_byte_transmitter.sv
// Byte-wide async serial transmitter: 8 data bits LSB first, 1 or 2 stop bits.
// Optional parity bit after the data when UART_TX_PARITY_EN is defined.
//
//  state     | meaning
//  ----------+--------------------------------------------------
//  ST_IDLE   | line high, waiting for TxD_start
//  ST_START  | driving the start bit (0)
//  ST_DATA   | driving data bits 0..7 from the shift register
//  ST_PARITY | driving the parity bit (UART_TX_PARITY_EN only)
//  ST_STOP   | driving STOP_BITS stop bits (1)
module uart_byte_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       master_clock,
  input  logic       reset,
  input  logic       TxD_start,
  input  logic [7:0] TxD_data,
  output logic       TxD_busy,
  output logic       TxD
);

  localparam int   DIV       = baud_div(CLK_FREQ, BAUD);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_byte_transmitter: STOP_BITS must be 1 or 2");
  end
  if (DIV < 2) begin : g_bad_div
    $error("uart_byte_transmitter: CLK_FREQ/BAUD must round to at least 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
    $error("uart_byte_transmitter: PARITY_ODD must be 0 or 1");
  end

  state_t     state_q,    state_d;
  logic [7:0] shift_q,    shift_d;
  logic [2:0] bit_idx_q,  bit_idx_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       txd_q,      txd_d;
  logic       busy_q,     busy_d;
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_INV = (PARITY_ODD != 0);
  logic       parity_q,   parity_d;
`endif

  logic tick;
  logic baud_clear;
  logic accept;

  assign accept     = TxD_start && !busy_q && (state_q == ST_IDLE);
  // Holding the counter at 0 while idle makes the start bit a full DIV cycles.
  assign baud_clear = (state_q == ST_IDLE);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .master_clock (master_clock),
    .reset        (reset),
    .clear        (baud_clear),
    .tick         (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      ST_IDLE: begin
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (accept) begin
          state_d    = ST_START;
          shift_d    = TxD_data;
          bit_idx_d  = 3'd0;
          stop_cnt_d = 1'b0;
          txd_d      = 1'b0;
          busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d   = (^TxD_data) ^ PAR_INV;
`endif
        end
      end

      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d    = ST_PARITY;
            txd_d      = parity_q;
`else
            state_d    = ST_STOP;
            stop_cnt_d = 1'b0;
            txd_d      = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
          txd_d      = 1'b1;
        end
      end
`endif

      ST_STOP: begin
        txd_d = 1'b1;
        if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge master_clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= 8'h00;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign TxD      = txd_q;
  assign TxD_busy = busy_q;

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Bench for uart_byte_transmitter at DIV=10; build with UART_TX_PARITY_EN for the 8E2 case.
module tb_uart_byte_transmitter;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD       = 100_000;
  localparam int DIV        = 10;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int NSTOP = 2;
  localparam int NPAR  = 1;
`else
  localparam int NSTOP = 1;
  localparam int NPAR  = 0;
`endif
  localparam int NBITS = 10 + NPAR + NSTOP - 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] data;
  logic       busy;
  logic       txd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_byte_transmitter #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .STOP_BITS (NSTOP),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .master_clock(clk),
    .reset       (reset),
    .TxD_start   (start),
    .TxD_data    (data),
    .TxD_busy    (busy),
    .TxD         (txd)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Line level of frame bit k for byte b, straight from the frame definition.
  function automatic logic frame_level(input logic [7:0] b, input int k);
    int ones;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NPAR == 1 && k == 9) begin
      ones = $countones(b);
      return logic'((ones % 2) != PARITY_ODD);
    end
    return 1'b1;
  endfunction

  task automatic idle_check(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      total++;
      if (txd !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL %s idle cyc=%0d txd=%b busy=%b want txd=1 busy=0", tag, i, txd, busy);
      end
    end
  endtask

  // Strobe for byte b must already be driven. noise: 0 quiet, 1 random strobes/data,
  // 2 single 0xFF strobe at cycle 30, 3 strobe held high throughout.
  task automatic check_frame(input logic [7:0] b, input int noise, input bit next_valid,
                             input logic [7:0] next_b, input string tag);
    int         len;
    logic       exp;
    logic [7:0] got;
    len = NBITS * DIV;
    got = 8'h00;
    step();
    if (noise != 3) start = 1'b0;
    for (int c = 0; c < len; c++) begin
      exp = frame_level(b, c / DIV);
      total++;
      if (txd !== exp || busy !== 1'b1) begin
        bad++;
        $display("FAIL %s cyc=%0d txd=%b busy=%b want txd=%b busy=1", tag, c, txd, busy, exp);
      end
      if ((c % DIV) == DIV / 2 && (c / DIV) >= 1 && (c / DIV) <= 8) got[c/DIV-1] = txd;
      if (noise == 1) begin
        data  = 8'($urandom);
        start = 1'($urandom_range(0, 1));
      end else if (noise == 2) begin
        start = (c == 30);
        data  = (c == 30) ? 8'hFF : 8'($urandom);
      end
      step();
    end
    total++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s end txd=%b busy=%b want txd=1 busy=0", tag, txd, busy);
    end
    total++;
    if (got !== b) begin
      bad++;
      $display("FAIL %s decode got=%02h want=%02h", tag, got, b);
    end
    if (next_valid) begin
      start = 1'b1;
      data  = next_b;
    end else if (noise != 3) begin
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    data  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (txd !== 1'b1 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset cyc=%0d txd=%b busy=%b want txd=1 busy=0", i, txd, busy);
      end
    end
    reset = 1'b0;
    idle_check(50, "reset_idle");
  endtask

  task automatic test_basic();
    data  = 8'h55;
    start = 1'b1;
    check_frame(8'h55, 0, 1'b0, 8'h00, "basic55");
    idle_check(5, "basic_idle");
  endtask

  task automatic test_back_to_back();
    data  = 8'hA3;
    start = 1'b1;
    check_frame(8'hA3, 0, 1'b1, 8'h0F, "b2b_a3");
    check_frame(8'h0F, 0, 1'b0, 8'h00, "b2b_0f");
    idle_check(5, "b2b_idle");
  endtask

  task automatic test_busy_strobe();
    data  = 8'h12;
    start = 1'b1;
    check_frame(8'h12, 2, 1'b0, 8'h00, "busy12");
    idle_check(DIV * 3, "busy_idle");
  endtask

  task automatic test_held_strobe();
    data  = 8'h3C;
    start = 1'b1;
    check_frame(8'h3C, 3, 1'b0, 8'h00, "held1");
    check_frame(8'h3C, 0, 1'b0, 8'h00, "held2");
    idle_check(5, "held_idle");
  endtask

  task automatic test_reset_mid();
    data  = 8'h00;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 45; c++) begin
      total++;
      if (txd !== frame_level(8'h00, c / DIV) || busy !== 1'b1) begin
        bad++;
        $display("FAIL rstmid cyc=%0d txd=%b busy=%b", c, txd, busy);
      end
      step();
    end
    reset = 1'b1;
    step();
    total++;
    if (txd !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_edge txd=%b busy=%b want txd=1 busy=0", txd, busy);
    end
    reset = 1'b0;
    idle_check(DIV * 12, "rstmid_idle");
    data  = 8'h81;
    start = 1'b1;
    check_frame(8'h81, 0, 1'b0, 8'h00, "rstmid81");
    idle_check(5, "rstmid_idle2");
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic [7:0] nb;
    bit         nv;
    b     = 8'($urandom);
    data  = b;
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nb = 8'($urandom);
      nv = (i < 7) && ($urandom_range(0, 1) == 1);
      check_frame(b, 1, nv, nb, "rnd");
      if (!nv && i < 7) begin
        idle_check($urandom_range(1, 4), "rnd_idle");
        data  = nb;
        start = 1'b1;
      end
      b = nb;
    end
    idle_check(5, "rnd_end");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    data  = 8'h07;
    start = 1'b1;
    check_frame(8'h07, 0, 1'b0, 8'h00, "par07");
    idle_check(5, "par_idle");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_busy_strobe();
    test_held_strobe();
    test_reset_mid();
    test_random();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
